// File: rtl/arbitro_acumulador.sv
// rtl/arbitro_acumulador.sv - round-robin shared accumulator with tick-paced job sequencing
module arbitro_acumulador #(
    parameter int DIV       = 5,
    parameter int NUM_SUMAS = 5,
    parameter int WIDTH     = 4
) (
    input  logic             clk100MHz,
    input  logic             reset,
    input  logic             inicio_a,
    input  logic [WIDTH-1:0] entrada_a,
    input  logic             inicio_b,
    input  logic [WIDTH-1:0] entrada_b,
    output logic             tick,
    output logic [1:0]       concesion,
    output logic             ocupado,
    output logic [WIDTH-1:0] Resultado,
    output logic             desborde,
    output logic             listo_a,
    output logic             listo_b
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        SUMA   = 2'd1,
        FIN    = 2'd2
    } estado_t;

    estado_t          estado, estado_sig;
    logic [CW-1:0]    cuenta_div;
    logic [3:0]       sumas;
    logic             gnt_b;
    logic             ptr_b;
    logic             pedido;
    logic             sel_b;
    logic             inicio_g;
    logic [WIDTH-1:0] operando;
    logic [WIDTH:0]   suma_ext;

    // Free-running divider; the enable tick paces every addition.
    always_ff @(posedge clk100MHz) begin
        if (!reset) begin
            cuenta_div <= '0;
        end else if (cuenta_div == CW'(DIV - 1)) begin
            cuenta_div <= '0;
        end else begin
            cuenta_div <= cuenta_div + 1'b1;
        end
    end

    assign tick = (cuenta_div == CW'(DIV - 1));

    assign pedido   = inicio_a | inicio_b;
    assign sel_b    = inicio_b & (~inicio_a | ptr_b);
    assign inicio_g = gnt_b ? inicio_b : inicio_a;
    assign operando = gnt_b ? entrada_b : entrada_a;
    assign suma_ext = {1'b0, Resultado} + {1'b0, operando};

    always_ff @(posedge clk100MHz) begin
        if (!reset) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO: if (pedido) estado_sig = SUMA;
            SUMA: begin
                if (!inicio_g) begin
                    estado_sig = REPOSO;
                end else if (tick && (sumas == 4'(NUM_SUMAS - 1))) begin
                    estado_sig = FIN;
                end
            end
            FIN:     estado_sig = REPOSO;
            default: estado_sig = REPOSO;
        endcase
    end

    // An abort (granted request dropped) wins over a coincident tick.
    always_ff @(posedge clk100MHz) begin
        if (!reset) begin
            gnt_b     <= 1'b0;
            ptr_b     <= 1'b0;
            sumas     <= '0;
            Resultado <= '0;
            desborde  <= 1'b0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (pedido) begin
                        gnt_b     <= sel_b;
                        sumas     <= '0;
                        Resultado <= '0;
                        desborde  <= 1'b0;
                    end
                end
                SUMA: begin
                    if (inicio_g && tick) begin
                        Resultado <= suma_ext[WIDTH-1:0];
                        desborde  <= desborde | suma_ext[WIDTH];
                        sumas     <= sumas + 1'b1;
                    end
                end
                FIN:     ptr_b <= ~gnt_b;
                default: ;
            endcase
        end
    end

    always_comb begin
        concesion = 2'b00;
        ocupado   = 1'b0;
        listo_a   = 1'b0;
        listo_b   = 1'b0;
        if (estado == SUMA || estado == FIN) begin
            concesion = gnt_b ? 2'b10 : 2'b01;
            ocupado   = 1'b1;
        end
        if (estado == FIN) begin
            listo_a = ~gnt_b;
            listo_b = gnt_b;
        end
    end

endmodule

// File: tb/tb_arbitro_acumulador.sv
// tb/tb_arbitro_acumulador.sv - scoreboard bench for arbitro_acumulador
module tb_arbitro_acumulador;

    localparam int DIV = 5;
    localparam int NS  = 5;
    localparam int W   = 4;

    logic         clk100MHz = 1'b0;
    logic         reset     = 1'b0;
    logic         inicio_a  = 1'b0;
    logic [W-1:0] entrada_a = '0;
    logic         inicio_b  = 1'b0;
    logic [W-1:0] entrada_b = '0;
    logic         tick;
    logic [1:0]   concesion;
    logic         ocupado;
    logic [W-1:0] Resultado;
    logic         desborde;
    logic         listo_a;
    logic         listo_b;

    always #5 clk100MHz = ~clk100MHz;

    arbitro_acumulador #(.DIV(DIV), .NUM_SUMAS(NS), .WIDTH(W)) dut (
        .clk100MHz (clk100MHz),
        .reset     (reset),
        .inicio_a  (inicio_a),
        .entrada_a (entrada_a),
        .inicio_b  (inicio_b),
        .entrada_b (entrada_b),
        .tick      (tick),
        .concesion (concesion),
        .ocupado   (ocupado),
        .Resultado (Resultado),
        .desborde  (desborde),
        .listo_a   (listo_a),
        .listo_b   (listo_b)
    );

    int total = 0;
    int bad   = 0;
    int n_listo_b = 0;

    typedef struct {
        int who;
        int res;
        int ovf;
    } job_t;

    job_t sb[$];

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic job_t model(input int who, input int op);
        job_t j;
        j.who = who;
        j.res = 0;
        j.ovf = 0;
        for (int i = 0; i < NS; i++) begin
            j.res += op;
            if (j.res >= (1 << W)) begin
                j.res -= (1 << W);
                j.ovf = 1;
            end
        end
        return j;
    endfunction

    // Reference divider phase, advanced on the same edges the DUT uses.
    int fase = 0;
    always @(posedge clk100MHz) begin
        if (!reset) fase <= 0;
        else        fase <= (fase == DIV - 1) ? 0 : fase + 1;
    end

    always @(negedge clk100MHz) begin
        check("tick_phase", int'(tick), int'(fase == DIV - 1));
        if (listo_a || listo_b) begin
            job_t j;
            n_listo_b += int'(listo_b);
            check("listo_onehot", int'(listo_a && listo_b), 0);
            if (sb.size() == 0) begin
                check("listo_unexpected", 1, 0);
            end else begin
                j = sb.pop_front();
                check("listo_who", int'(listo_b), j.who);
                check("res", int'(Resultado), j.res);
                check("ovf", int'(desborde), j.ovf);
                check("conc_fin", int'(concesion), j.who ? 2 : 1);
            end
        end
    end

    task automatic ciclo();
        @(posedge clk100MHz);
        #1;
    endtask

    task automatic wait_listo(output int dur, output bit ok);
        dur = 0;
        ok  = 1'b0;
        for (int i = 0; i < NS * DIV + 10; i++) begin
            @(negedge clk100MHz);
            if (listo_a || listo_b) begin
                ok = 1'b1;
                break;
            end
            dur++;
        end
        if (!ok) check("listo_timeout", 0, 1);
    endtask

    task automatic check_zero(input string tag);
        check(tag, int'({tick, concesion, ocupado, Resultado, desborde, listo_a, listo_b}), 0);
    endtask

    task automatic run_job(input int who, input int op);
        job_t e;
        int   dur;
        bit   ok;
        e = model(who, op);
        ciclo();
        if (who == 0) begin inicio_a = 1'b1; entrada_a = W'(op); end
        else          begin inicio_b = 1'b1; entrada_b = W'(op); end
        sb.push_back(e);
        @(negedge clk100MHz);
        check("grant_lat", int'(concesion), 0);
        @(negedge clk100MHz);
        check("grant", int'(concesion), who ? 2 : 1);
        check("ocupado_on", int'(ocupado), 1);
        wait_listo(dur, ok);
        inicio_a = 1'b0;
        inicio_b = 1'b0;
        if (ok) begin
            check("dur_lo", int'(dur + 1 >= (NS - 1) * DIV + 1), 1);
            check("dur_hi", int'(dur + 1 <= NS * DIV), 1);
        end
        @(negedge clk100MHz);
        check("ocupado_off", int'(ocupado), 0);
        check("conc_idle", int'(concesion), 0);
        check("res_hold", int'(Resultado), e.res);
        check("ovf_hold", int'(desborde), e.ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  nt;
        int  dur;
        bit  ok;
        int  whos[4];
        whos = '{0, 1, 0, 1};

        // Reset state and divider cadence.
        repeat (3) begin
            @(negedge clk100MHz);
            check_zero("reset_outputs");
        end
        ciclo();
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk100MHz);
            n++;
            if (tick) break;
        end
        check("first_tick", n, DIV);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            for (int i = 0; i < 4 * DIV; i++) begin
                @(negedge clk100MHz);
                n++;
                if (tick) break;
            end
            check("tick_period", n, DIV);
        end

        // Single-requester jobs: with and without carry.
        run_job(0, 5);
        run_job(0, 3);
        check("listo_b_quiet", n_listo_b, 0);

        // Both requesting right after reset: A, B, A, B.
        ciclo();
        reset = 1'b0;
        ciclo();
        ciclo();
        reset     = 1'b1;
        inicio_a  = 1'b1;
        inicio_b  = 1'b1;
        entrada_a = 4'd5;
        entrada_b = 4'd2;
        for (int k = 0; k < 4; k++) sb.push_back(model(whos[k], whos[k] ? 2 : 5));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk100MHz);
            check("rr_idle", int'(concesion), 0);
            @(negedge clk100MHz);
            check("rr_grant", int'(concesion), whos[k] ? 2 : 1);
            wait_listo(dur, ok);
        end
        inicio_a = 1'b0;
        inicio_b = 1'b0;
        @(negedge clk100MHz);

        // Abort A after two additions; pointer must stay on A.
        ciclo();
        inicio_a  = 1'b1;
        entrada_a = 4'd5;
        @(negedge clk100MHz);
        @(negedge clk100MHz);
        check("abort_grant", int'(concesion), 1);
        nt = 0;
        for (int i = 0; i < 3 * DIV + 5; i++) begin
            if (tick && concesion == 2'b01) nt++;
            if (nt == 2) break;
            @(negedge clk100MHz);
        end
        check("abort_ticks", nt, 2);
        ciclo();
        inicio_a = 1'b0;
        @(negedge clk100MHz);
        @(negedge clk100MHz);
        check("abort_conc", int'(concesion), 0);
        check("abort_ocupado", int'(ocupado), 0);
        check("abort_res", int'(Resultado), 10);
        check("abort_ovf", int'(desborde), 0);
        ciclo();
        inicio_a  = 1'b1;
        inicio_b  = 1'b1;
        entrada_a = 4'd3;
        entrada_b = 4'd2;
        sb.push_back(model(0, 3));
        @(negedge clk100MHz);
        @(negedge clk100MHz);
        check("ptr_kept", int'(concesion), 1);
        wait_listo(dur, ok);
        inicio_a = 1'b0;
        inicio_b = 1'b0;
        @(negedge clk100MHz);

        // Reset in the middle of a B job, then a fresh job.
        ciclo();
        inicio_b  = 1'b1;
        entrada_b = 4'd2;
        @(negedge clk100MHz);
        @(negedge clk100MHz);
        check("pre_reset_grant", int'(concesion), 2);
        repeat (7) @(negedge clk100MHz);
        ciclo();
        reset    = 1'b0;
        inicio_b = 1'b0;
        @(negedge clk100MHz);
        @(negedge clk100MHz);
        check_zero("midjob_reset");
        ciclo();
        reset = 1'b1;
        run_job(0, 3);

        @(negedge clk100MHz);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
